sram_cache_controller: RTL and testbench

//  2-way set-associative, write-through, no-write-allocate word cache between the

---
 rtl/sram_cache_controller.sv | 148 ++++++++++++++
 tb/tb_sram_cache_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sram_cache_controller.sv
// rtl/sram_cache_controller.sv - 2-way set-associative write-through word cache in front of the SRAM controller
`timescale 1ns/1ps
module sram_cache_controller #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] SRAM_address,
    output logic [31:0] SRAM_write_data,
    output logic        SRAM_re_en,
    output logic        SRAM_we_en,
    input  logic [31:0] SRAM_read_data,
    input  logic        SRAM_ready
);
    localparam int SETS = 1 << INDEX_W;

    typedef enum logic [1:0] {S_IDLE, S_READ_MISS, S_WRITE} state_t;
    state_t r_state;
    state_t w_next;

    logic [SETS-1:0]  r_valid0;
    logic [SETS-1:0]  r_valid1;
    logic [SETS-1:0]  r_lru;
    logic [TAG_W-1:0] r_tag0  [SETS];
    logic [TAG_W-1:0] r_tag1  [SETS];
    logic [31:0]      r_data0 [SETS];
    logic [31:0]      r_data1 [SETS];

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_match0;
    logic               w_match1;
    logic               w_hit0;
    logic               w_hit1;
    logic               w_hit;
    logic               w_fill;
    logic               w_fill_way;
    logic               w_wr_hit;
    logic               w_wr_way;
    logic               w_rd_hit;
    logic               w_unused;

    assign w_index  = address[INDEX_W+1:2];
    assign w_tag    = address[18:INDEX_W+2];
    assign w_unused = ^{address[31:19], address[1:0]};

    assign SRAM_address    = {address[18:2], 1'b0};
    assign SRAM_write_data = write_data;

    // Tag lookup in both ways; a hit is only meaningful for a load.
    assign w_match0 = r_valid0[w_index] && (r_tag0[w_index] == w_tag);
    assign w_match1 = r_valid1[w_index] && (r_tag1[w_index] == w_tag);
    assign w_hit0   = MEM_R_EN && w_match0;
    assign w_hit1   = MEM_R_EN && w_match1;
    assign w_hit    = w_hit0 || w_hit1;

    assign read_data = w_hit0 ? r_data0[w_index] :
                       w_hit1 ? r_data1[w_index] : 32'd0;

    // Array update strobes: line fill at end of a miss, write-hit refresh, read-hit LRU touch.
    assign w_fill     = (r_state == S_READ_MISS) && SRAM_ready;
    assign w_fill_way = !r_valid0[w_index] ? 1'b0 :
                        !r_valid1[w_index] ? 1'b1 : r_lru[w_index];
    assign w_wr_hit   = (r_state == S_IDLE) && MEM_W_EN && (w_match0 || w_match1);
    assign w_wr_way   = !w_match0;
    assign w_rd_hit   = (r_state == S_IDLE) && !MEM_W_EN && w_hit;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake outputs; SRAM enables come from the state alone.
    always_comb begin
        w_next     = r_state;
        ready      = 1'b1;
        SRAM_re_en = 1'b0;
        SRAM_we_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MEM_W_EN) begin
                    w_next = S_WRITE;
                    ready  = 1'b0;
                end else if (MEM_R_EN && !w_hit) begin
                    w_next = S_READ_MISS;
                    ready  = 1'b0;
                end
            end
            S_READ_MISS: begin
                SRAM_re_en = 1'b1;
                ready      = 1'b0;
                if (SRAM_ready) w_next = S_IDLE;
            end
            S_WRITE: begin
                SRAM_we_en = 1'b1;
                ready      = SRAM_ready;
                if (SRAM_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Reset releases the pipeline immediately, even with a request still applied.
        if (rst) ready = 1'b1;
    end

    // Valid bits and LRU pointers; LRU names the next victim way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid0 <= '0;
            r_valid1 <= '0;
            r_lru    <= '0;
        end else if (w_fill) begin
            if (w_fill_way) r_valid1[w_index] <= 1'b1;
            else            r_valid0[w_index] <= 1'b1;
            r_lru[w_index] <= !w_fill_way;
        end else if (w_wr_hit) begin
            r_lru[w_index] <= !w_wr_way;
        end else if (w_rd_hit) begin
            r_lru[w_index] <= w_hit0;
        end
    end

    // Tag and data arrays are left uninitialised; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            if (w_fill_way) begin
                r_tag1[w_index]  <= w_tag;
                r_data1[w_index] <= SRAM_read_data;
            end else begin
                r_tag0[w_index]  <= w_tag;
                r_data0[w_index] <= SRAM_read_data;
            end
        end else if (w_wr_hit) begin
            if (w_wr_way) r_data1[w_index] <= write_data;
            else          r_data0[w_index] <= write_data;
        end
    end
endmodule

// File: tb/tb_sram_cache_controller.sv
// tb/tb_sram_cache_controller.sv - table-driven bench for sram_cache_controller with an SRAM handshake model
`timescale 1ns/1ps
module tb_sram_cache_controller;
    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] SRAM_address;
    logic [31:0] SRAM_write_data;
    logic        SRAM_re_en;
    logic        SRAM_we_en;
    logic [31:0] SRAM_read_data;
    logic        SRAM_ready;

    int n_checks = 0;
    int n_fail   = 0;

    sram_cache_controller #(.INDEX_W(6), .TAG_W(11)) dut (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .read_data(read_data), .ready(ready),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
        .SRAM_re_en(SRAM_re_en), .SRAM_we_en(SRAM_we_en),
        .SRAM_read_data(SRAM_read_data), .SRAM_ready(SRAM_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM controller model: busy 3 cycles then ready 1 cycle while enabled.
    logic [1:0]  sram_cnt;
    logic [31:0] sram_mem     [131072];
    bit          sram_written [131072];
    logic        sram_en;

    assign sram_en    = SRAM_re_en || SRAM_we_en;
    assign SRAM_ready = !sram_en || (sram_cnt == 2'd3);

    function automatic logic [31:0] init_val(input logic [16:0] w);
        case (w)
            17'h00040: return 32'hDEADBEEF;
            17'h01040: return 32'h11114100;
            17'h02040: return 32'h22228100;
            default:   return 32'h0;
        endcase
    endfunction

    assign SRAM_read_data = sram_written[SRAM_address[17:1]] ? sram_mem[SRAM_address[17:1]]
                                                             : init_val(SRAM_address[17:1]);

    always @(posedge clk) begin
        if (sram_en) sram_cnt <= sram_cnt + 2'd1;
        else         sram_cnt <= 2'd0;
        if (SRAM_we_en && SRAM_ready) begin
            sram_mem[SRAM_address[17:1]]     <= SRAM_write_data;
            sram_written[SRAM_address[17:1]] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          do_rst;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic [17:0] exp_saddr;
        int          exp_stall;
        int          exp_re;
        int          exp_we;
    } vec_t;

    vec_t vecs [15];

    task automatic do_reset(input string name);
        @(negedge clk);
        rst      = 1'b1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        #1;
        chk({name, " rst ready"}, {31'd0, ready}, 32'd1);
        chk({name, " rst re_en"}, {31'd0, SRAM_re_en}, 32'd0);
        chk({name, " rst we_en"}, {31'd0, SRAM_we_en}, 32'd0);
        chk({name, " rst read_data"}, read_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts stall/enable cycles until ready=1 is sampled, bounded by a cycle budget.
    task automatic measure(input string name, input bit first_now, input int exp_stall,
                           input int exp_re, input int exp_we, input bit chk_data,
                           input logic [31:0] exp_data);
        int stall = 0;
        int re = 0;
        int we = 0;
        bit done = 1'b0;
        logic [31:0] rd = 32'd0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (c > 0 || !first_now) begin
                @(negedge clk);
                #1;
            end
            if (SRAM_re_en) re++;
            if (SRAM_we_en) we++;
            if (ready) begin
                done = 1'b1;
                rd   = read_data;
            end else begin
                stall++;
            end
        end
        chk({name, " timeout"}, {31'd0, done}, 32'd1);
        chk({name, " stall cycles"}, stall, exp_stall);
        chk({name, " re_en cycles"}, re, exp_re);
        chk({name, " we_en cycles"}, we, exp_we);
        if (chk_data) chk({name, " read_data"}, rd, exp_data);
    endtask

    initial begin
        rst = 1'b0; address = '0; write_data = '0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h100,  32'h0,        32'hDEADBEEF, 18'h080,  5, 4, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h100,  32'h0,        32'hDEADBEEF, 18'h080,  0, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h100,  32'h12345678, 32'h0,        18'h080,  4, 0, 4};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h100,  32'h0,        32'h12345678, 18'h080,  0, 0, 0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h200,  32'hA5A5A5A5, 32'h0,        18'h100,  4, 0, 4};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h200,  32'h0,        32'hA5A5A5A5, 18'h100,  5, 4, 0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h100,  32'h0,        32'h12345678, 18'h080,  5, 4, 0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h4100, 32'h0,        32'h11114100, 18'h2080, 5, 4, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h8100, 32'h0,        32'h22228100, 18'h4080, 5, 4, 0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h4100, 32'h0,        32'h11114100, 18'h2080, 0, 0, 0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h100,  32'h0,        32'h12345678, 18'h080,  5, 4, 0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h8100, 32'h0,        32'h22228100, 18'h4080, 5, 4, 0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h100,  32'h0,        32'h12345678, 18'h080,  0, 0, 0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h300,  32'hCAFEF00D, 32'h0,        18'h180,  4, 0, 4};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h300,  32'h0,        32'hCAFEF00D, 18'h180,  5, 4, 0};

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].do_rst) do_reset($sformatf("v%0d", i));
            @(negedge clk);
            address    = vecs[i].addr;
            write_data = vecs[i].wdata;
            MEM_R_EN   = vecs[i].rd;
            MEM_W_EN   = vecs[i].wr;
            #1;
            chk($sformatf("v%0d SRAM_address", i), {14'd0, SRAM_address}, {14'd0, vecs[i].exp_saddr});
            if (vecs[i].wr)
                chk($sformatf("v%0d re_en blocked", i), {31'd0, SRAM_re_en}, 32'd0);
            measure($sformatf("v%0d", i), 1'b1, vecs[i].exp_stall, vecs[i].exp_re,
                    vecs[i].exp_we, vecs[i].rd && !vecs[i].wr, vecs[i].exp_data);
        end

        // Reset pulse in the second READ_MISS cycle, released before any clock edge.
        do_reset("t5");
        @(negedge clk);
        address = 32'h100; write_data = 32'h0; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0;
        #1;
        chk("t5 idle miss ready", {31'd0, ready}, 32'd0);
        @(negedge clk); #1;
        chk("t5 miss1 re_en", {31'd0, SRAM_re_en}, 32'd1);
        @(negedge clk); #1;
        chk("t5 miss2 re_en", {31'd0, SRAM_re_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t5 async re_en", {31'd0, SRAM_re_en}, 32'd0);
        chk("t5 async ready", {31'd0, ready}, 32'd1);
        chk("t5 async read_data", read_data, 32'd0);
        rst = 1'b0;
        #1;
        chk("t5 post-rst miss ready", {31'd0, ready}, 32'd0);
        measure("t5 refetch", 1'b0, 4, 4, 0, 1'b1, 32'h12345678);

        @(negedge clk);
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        #1;
        chk("end idle ready", {31'd0, ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
